// File: rtl/uart_rx_if.sv
// Serial receive port bundle: line, per-frame configuration and received-frame results.
// The master side drives the line and configuration; the slave (receiver) returns results.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP2;
  logic [PRESCALE_W-1:0] Prescale;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_error;
  logic                  stop_error;
  logic                  busy;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, STOP2, Prescale,
    input  P_DATA, data_valid, par_error, stop_error, busy
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, STOP2, Prescale,
    output P_DATA, data_valid, par_error, stop_error, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART frame receiver: oversampled start/data/parity/stop decoding with 2-of-3 majority
// voting per bit, one-cycle result pulses and break handling after framing errors.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);
  localparam int CW = (PRESCALE_W < 4) ? 4 : PRESCALE_W;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            bit_idx_q, bit_idx_d;
  logic                  armed_q, armed_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_error_q, par_error_d;
  logic                  stop_error_q, stop_error_d;
  logic                  busy_q, busy_d;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [2:0]            samp_q, samp_d;
  logic                  par_acc_q, par_acc_d;
  logic                  par_bad_q, par_bad_d;
  logic                  stop_bad_q, stop_bad_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  stop2_q, stop2_d;
  logic [CW-1:0]         presc_q, presc_d;

  logic [CW-1:0]         mid;
  logic                  bit_end;
  logic                  vote;
  logic                  stop_fail;
  logic                  latch_cfg;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  function automatic logic [CW-1:0] clamp_presc(input logic [PRESCALE_W-1:0] p);
    logic [CW-1:0] w;
    w = CW'(p);
    return (w < CW'(8)) ? CW'(8) : w;
  endfunction

  assign mid     = presc_q >> 1;
  assign bit_end = (cnt_q == presc_q - CW'(1));
  assign vote    = maj3(samp_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    armed_d      = armed_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_error_d  = 1'b0;
    stop_error_d = 1'b0;
    shift_d      = shift_q;
    par_acc_d    = par_acc_q;
    par_bad_d    = par_bad_q;
    stop_bad_d   = stop_bad_q;
    latch_cfg    = 1'b0;
    stop_fail    = stop_bad_q | ~vote;

    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + CW'(1);

    unique case (state_q)
      IDLE: begin
        // After a framing error the line must be seen high before a new start is accepted
        if (!armed_q) begin
          armed_d = bus.RX_IN;
        end else if (!bus.RX_IN) begin
          state_d   = START;
          cnt_d     = '0;
          latch_cfg = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          if (vote) begin
            state_d = IDLE;
          end else begin
            state_d    = DATA;
            bit_idx_d  = '0;
            par_acc_d  = 1'b0;
            par_bad_d  = 1'b0;
            stop_bad_d = 1'b0;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = {vote, shift_q[DATA_WIDTH-1:1]};
          par_acc_d = par_acc_q ^ vote;
          if (bit_idx_q == 4'(DATA_WIDTH - 1)) begin
            bit_idx_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_bad_d = ((par_acc_q ^ vote) != par_typ_q);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_idx_q != {3'b000, stop2_q}) begin
            stop_bad_d = stop_fail;
            bit_idx_d  = bit_idx_q + 4'd1;
          end else if (stop_fail) begin
            stop_error_d = 1'b1;
            state_d      = IDLE;
            armed_d      = 1'b0;
          end else begin
            if (par_bad_q) begin
              par_error_d = 1'b1;
            end else begin
              data_valid_d = 1'b1;
              p_data_d     = shift_q;
            end
            // A low line at the last stop boundary is the next frame's start bit
            if (!bus.RX_IN) begin
              state_d   = START;
              latch_cfg = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_comb begin
    samp_d = samp_q;
    if (cnt_q == mid - CW'(1)) samp_d[0] = bus.RX_IN;
    if (cnt_q == mid)          samp_d[1] = bus.RX_IN;
    if (cnt_q == mid + CW'(1)) samp_d[2] = bus.RX_IN;

    par_en_d  = latch_cfg ? bus.PAR_EN                : par_en_q;
    par_typ_d = latch_cfg ? bus.PAR_TYP               : par_typ_q;
    stop2_d   = latch_cfg ? bus.STOP2                 : stop2_q;
    presc_d   = latch_cfg ? clamp_presc(bus.Prescale) : presc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      armed_q      <= 1'b1;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_error_q  <= 1'b0;
      stop_error_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      armed_q      <= armed_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_error_q  <= par_error_d;
      stop_error_q <= stop_error_d;
      busy_q       <= busy_d;
    end
  end

  // Datapath and latched frame configuration carry no reset; control qualifies their use
  always_ff @(posedge clk) begin
    shift_q    <= shift_d;
    samp_q     <= samp_d;
    par_acc_q  <= par_acc_d;
    par_bad_q  <= par_bad_d;
    stop_bad_q <= stop_bad_d;
    par_en_q   <= par_en_d;
    par_typ_q  <= par_typ_d;
    stop2_q    <= stop2_d;
    presc_q    <= presc_d;
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.par_error  = par_error_q;
  assign bus.stop_error = stop_error_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are built from their bit lists, expected outcomes
// are queued at send time, and a monitor matches every result pulse against the queue.
module tb_uart_rx_ctrl;
  localparam int DW = 8;
  localparam int PW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  uart_rx_if #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) bus ();

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = data_valid, 1 = par_error, 2 = stop_error
  typedef struct {
    int            at;
    int            kind;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] last_good;

  always @(negedge clk) begin
    if (!rst && (bus.data_valid || bus.par_error || bus.stop_error)) begin : mon
      int   kind;
      exp_t e;
      checks++;
      if (int'(bus.data_valid) + int'(bus.par_error) + int'(bus.stop_error) != 1) begin
        errors++;
        $display("FAIL onehot: got dv=%0b pe=%0b se=%0b required exactly one", bus.data_valid,
                 bus.par_error, bus.stop_error);
      end
      kind = bus.stop_error ? 2 : (bus.par_error ? 1 : 0);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got kind=%0d at cyc=%0d required no pulse", kind, cyc);
      end else begin
        e = exp_q.pop_front();
        if (kind != e.kind || cyc != e.at || bus.P_DATA !== e.data) begin
          errors++;
          $display("FAIL pulse: got kind=%0d cyc=%0d P_DATA=%h required kind=%0d cyc=%0d P_DATA=%h",
                   kind, cyc, bus.P_DATA, e.kind, e.at, e.data);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.RX_IN = 1'b1;
    step(n);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Drives one complete frame starting in the current cycle and queues its expected result.
  task automatic send_frame(input logic [DW-1:0] d, input bit pe, input bit pt, input bit s2,
                            input int presc, input bit bad_par, input bit [1:0] bad_stop,
                            input bit glitch);
    int   peff;
    int   n;
    int   kind;
    logic p;
    logic bits[$];
    peff = (presc < 8) ? 8 : presc;
    p    = (^d) ^ pt;
    if (bad_par) p = ~p;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(p);
    bits.push_back(~bad_stop[0]);
    if (s2) bits.push_back(~bad_stop[1]);
    n = bits.size();
    if (bad_stop[0] || (s2 && bad_stop[1])) kind = 2;
    else if (pe && bad_par)                 kind = 1;
    else                                    kind = 0;
    if (kind == 0) last_good = d;
    exp_q.push_back('{cyc + 1 + peff * n, kind, last_good});
    bus.PAR_EN   = pe;
    bus.PAR_TYP  = pt;
    bus.STOP2    = s2;
    bus.Prescale = PW'(presc);
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < peff; k++) begin
        bus.RX_IN = (glitch && b >= 1 && b <= DW && k == peff / 2 + 1) ? ~bits[b] : bits[b];
        if (b == 0 && k == 1) begin
          bus.PAR_EN   = 1'($urandom);
          bus.PAR_TYP  = 1'($urandom);
          bus.STOP2    = 1'($urandom);
          bus.Prescale = PW'($urandom);
        end
        step();
      end
    end
  endtask

  task automatic random_frames(input int nfr);
    logic [DW-1:0] d;
    bit            pe, pt, s2, bp, gl;
    bit [1:0]      bs;
    int            pr;
    for (int i = 0; i < nfr; i++) begin
      d  = DW'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      s2 = 1'($urandom);
      pr = 2 * $urandom_range(4, 16);
      bp = ($urandom_range(0, 5) == 0);
      bs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      gl = 1'($urandom);
      send_frame(d, pe, pt, s2, pr, bp, bs, gl);
      if (bs[0] || (s2 && bs[1])) idle($urandom_range(3, 6));
      else if ((pe && bp) || $urandom_range(0, 3) != 0) idle($urandom_range(1, 6));
    end
  endtask

  initial begin
    bus.RX_IN    = 1'b1;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    bus.STOP2    = 1'b0;
    bus.Prescale = PW'(8);
    last_good    = '0;
    step(3);
    check("rst_p_data", 32'(bus.P_DATA), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_pulses", {29'd0, bus.data_valid, bus.par_error, bus.stop_error}, 0);
    rst = 1'b0;
    idle(4);

    // 8N1 at the minimum prescale
    send_frame(8'hA5, 0, 0, 0, 8, 0, 2'b00, 0);
    idle(4);
    check("a5_p_data", 32'(bus.P_DATA), 32'hA5);
    check("a5_busy_after", 32'(bus.busy), 0);

    // odd parity with wrong parity bit: rejected, data held
    send_frame(8'h3C, 1, 1, 0, 16, 1, 2'b00, 0);
    idle(4);
    check("par_hold_p_data", 32'(bus.P_DATA), 32'hA5);

    // three-cycle start glitch
    bus.Prescale = PW'(16);
    bus.RX_IN    = 1'b0;
    step(3);
    bus.RX_IN = 1'b1;
    step(5);
    check("glitch_busy_mid", 32'(bus.busy), 1);
    step(12);
    check("glitch_busy_after", 32'(bus.busy), 0);

    // second stop bit low, then a held break
    send_frame(8'h96, 0, 0, 1, 8, 0, 2'b10, 0);
    bus.RX_IN = 1'b0;
    step(40);
    check("break_no_start", 32'(bus.busy), 0);
    idle(3);

    // back-to-back frames
    send_frame(8'h55, 0, 0, 0, 8, 0, 2'b00, 0);
    send_frame(8'h0F, 0, 0, 0, 8, 0, 2'b00, 0);
    idle(4);
    check("b2b_p_data", 32'(bus.P_DATA), 32'h0F);

    // single-cycle inversion at the centre sample of every data bit
    send_frame(8'hC3, 0, 0, 0, 16, 0, 2'b00, 1);
    idle(4);
    check("vote_p_data", 32'(bus.P_DATA), 32'hC3);

    // prescale below the minimum behaves as 8
    send_frame(8'h5A, 1, 0, 0, 6, 0, 2'b00, 0);
    idle(4);

    random_frames(40);
    idle(4);

    // reset in the middle of the data bits
    bus.Prescale = PW'(8);
    bus.PAR_EN   = 1'b0;
    bus.STOP2    = 1'b0;
    bus.RX_IN    = 1'b0;
    step(8);
    bus.RX_IN = 1'b1;
    step(20);
    check("mid_frame_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    step(2);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_p_data", 32'(bus.P_DATA), 0);
    check("abort_pulses", {29'd0, bus.data_valid, bus.par_error, bus.stop_error}, 0);
    rst       = 1'b0;
    last_good = '0;
    idle(5);
    send_frame(8'h81, 0, 0, 1, 10, 0, 2'b00, 0);
    idle(20);

    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) step();
    check("queue_drained", 32'(exp_q.size()), 0);
    check("final_p_data", 32'(bus.P_DATA), 32'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
